// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, pipeline control inputs and IF/ID outputs.
// The fetch unit drives it through the master modport.
interface fetch_unit_if;
  logic [7:0] imem_data;
  logic [7:0] imem_addr;
  logic       stall;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       intr;
  logic [3:0] if_opcode;
  logic [1:0] if_ra;
  logic [1:0] if_rb;
  logic [7:0] if_imm;
  logic [7:0] if_pc_next;
  logic       if_valid;
  logic       if_int;
  logic       intr_ack;

  modport master (
    input  imem_data, stall, pc_load, pc_load_val, intr,
    output imem_addr, if_opcode, if_ra, if_rb, if_imm, if_pc_next,
           if_valid, if_int, intr_ack
  );

  modport slave (
    output imem_data, stall, pc_load, pc_load_val, intr,
    input  imem_addr, if_opcode, if_ra, if_rb, if_imm, if_pc_next,
           if_valid, if_int, intr_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with reset vector, two-byte (opcode 4'hC) instructions and IF/ID register.
// Define FETCH_INTR_EN to build the interrupt injection logic (pending flag, saved pc, INT_VEC).
module fetch_unit (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {RST_VEC, FETCH, FETCH_IMM, INT_VEC} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] opcode_q, opcode_d;
  logic [1:0] ra_q, ra_d;
  logic [1:0] rb_q, rb_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] pc_next_q, pc_next_d;
  logic       valid_q, valid_d;
  logic [7:0] pc_inc;
  logic [7:0] imem_addr_c;

`ifdef FETCH_INTR_EN
  logic       pend_q, pend_d;
  logic       intr_prev_q;
  logic       int_q, int_d;
  logic       ack_q, ack_d;
  logic [7:0] saved_pc_q, saved_pc_d;
  logic       intr_rise;

  assign intr_rise = bus.intr & ~intr_prev_q;
`else
  logic unused_intr;
  assign unused_intr = bus.intr;
`endif

  assign pc_inc = pc_q + 8'd1;

  always_comb begin
    imem_addr_c = pc_q;
    if (state_q == RST_VEC) imem_addr_c = 8'h00;
`ifdef FETCH_INTR_EN
    if (state_q == INT_VEC) imem_addr_c = 8'h01;
`endif
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    opcode_d  = opcode_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    imm_d     = imm_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
`ifdef FETCH_INTR_EN
    pend_d     = pend_q | intr_rise;
    saved_pc_d = saved_pc_q;
    int_d      = int_q;
    ack_d      = 1'b0;
`endif
    case (state_q)
      RST_VEC: begin
        pc_d    = bus.imem_data;
        state_d = FETCH;
      end

      FETCH: begin
        if (!bus.stall) begin
`ifdef FETCH_INTR_EN
          int_d = 1'b0;
`endif
          if (bus.pc_load) begin
            pc_d    = bus.pc_load_val;
            valid_d = 1'b0;
          end
`ifdef FETCH_INTR_EN
          // Interrupts are only taken here, at a clean instruction boundary.
          else if (pend_q) begin
            saved_pc_d = pc_q;
            ack_d      = 1'b1;
            pend_d     = 1'b0;
            valid_d    = 1'b0;
            state_d    = INT_VEC;
          end
`endif
          else if (bus.imem_data[7:4] == 4'hC) begin
            hold_d  = bus.imem_data;
            pc_d    = pc_inc;
            valid_d = 1'b0;
            state_d = FETCH_IMM;
          end
          else begin
            opcode_d  = bus.imem_data[7:4];
            ra_d      = bus.imem_data[3:2];
            rb_d      = bus.imem_data[1:0];
            imm_d     = 8'h00;
            pc_next_d = pc_inc;
            valid_d   = 1'b1;
            pc_d      = pc_inc;
          end
        end
      end

      FETCH_IMM: begin
        if (!bus.stall) begin
`ifdef FETCH_INTR_EN
          int_d = 1'b0;
`endif
          state_d = FETCH;
          if (bus.pc_load) begin
            pc_d    = bus.pc_load_val;
            valid_d = 1'b0;
          end
          else begin
            opcode_d  = hold_q[7:4];
            ra_d      = hold_q[3:2];
            rb_d      = hold_q[1:0];
            imm_d     = bus.imem_data;
            pc_next_d = pc_inc;
            valid_d   = 1'b1;
            pc_d      = pc_inc;
          end
        end
      end

`ifdef FETCH_INTR_EN
      INT_VEC: begin
        if (!bus.stall) begin
          pc_d      = bus.imem_data;
          int_d     = 1'b1;
          valid_d   = 1'b1;
          opcode_d  = 4'h0;
          ra_d      = 2'b00;
          rb_d      = 2'b00;
          imm_d     = 8'h00;
          pc_next_d = saved_pc_q;
          state_d   = FETCH;
        end
      end
`endif

      default: state_d = RST_VEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_VEC;
      pc_q      <= 8'h00;
      hold_q    <= 8'h00;
      opcode_q  <= 4'h0;
      ra_q      <= 2'b00;
      rb_q      <= 2'b00;
      imm_q     <= 8'h00;
      pc_next_q <= 8'h00;
      valid_q   <= 1'b0;
    end
    else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      opcode_q  <= opcode_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      imm_q     <= imm_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

`ifdef FETCH_INTR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= 1'b0;
      intr_prev_q <= 1'b0;
      int_q       <= 1'b0;
      ack_q       <= 1'b0;
      saved_pc_q  <= 8'h00;
    end
    else begin
      pend_q      <= pend_d;
      intr_prev_q <= bus.intr;
      int_q       <= int_d;
      ack_q       <= ack_d;
      saved_pc_q  <= saved_pc_d;
    end
  end

  assign bus.if_int   = int_q;
  assign bus.intr_ack = ack_q;
`else
  assign bus.if_int   = 1'b0;
  assign bus.intr_ack = 1'b0;
`endif

  assign bus.imem_addr  = imem_addr_c;
  assign bus.if_opcode  = opcode_q;
  assign bus.if_ra      = ra_q;
  assign bus.if_rb      = rb_q;
  assign bus.if_imm     = imm_q;
  assign bus.if_pc_next = pc_next_q;
  assign bus.if_valid   = valid_q;

endmodule
